vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Upstream timing stage for the VGA drawer: generates 640×480@60 Hz raster timing from the 25 MHz pixel clock and emits the pixel coordinates the drawer renders. It accepts the drawer's 16-bit RGB565 result, then outputs RGB together with sync and data-enable signals. Sync and enable are delayed so that colour, syncs and enable leave the block on the same clock edge.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIPE_DLY, 1, drawer latency in clocks from pix_x/pix_y to in_rgb; legal range 0..4

Ports:
- sys_clk  in  1  pixel clock, 25 MHz
- sys_rst_n  in  1  asynchronous active-low reset
- pix_x  out  10  column to draw; 0..639 in the visible area, 0 elsewhere
- pix_y  out  10  row to draw; 0..479 in the visible area, 0 elsewhere
- pix_req  out  1  high when pix_x/pix_y address a visible pixel
- frame_start  out  1  one-clock pulse coincident with pix_x=0, pix_y=0, pix_req=1
- in_rgb  in  16  drawer colour (RGB565), valid PIPE_DLY clocks after the matching pix_x/pix_y
- out_rgb  out  16  colour to the DAC; 16'h0000 whenever out_de=0
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- out_de  out  1  data enable, aligned with out_rgb
- pat_sel  in  1  test-pattern select; present only when VGA_TEST_PATTERN_EN is defined

## Operation
- Horizontal counter h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800, then wraps to 0.
- Vertical counter v_cnt advances only on the h_cnt wrap. It runs 0..V_TOTAL-1 (V_TOTAL = 525), then wraps to 0.
- Both counters are 10 bits.
- Horizontal regions by h_cnt:
  - visible: 0..639
  - front porch: 640..655
  - sync: 656..751
  - back porch: 752..799
- Vertical regions by v_cnt:
  - visible: 0..479
  - front porch: 480..489
  - sync: 490..491
  - back porch: 492..524
- Visible pixel: both counters are in their visible regions.
- Pixel stage (registered from the counters): pix_x, pix_y, pix_req, frame_start. Outside the visible area, pix_x and pix_y are forced to 0.
- Raw hsync, vsync and de are computed at the pixel stage. They pass through a shift register of depth PIPE_DLY+1.
- Output stage registers in_rgb into out_rgb. The register is gated: out_rgb = delayed_de ? in_rgb : 0.
- vsync is asserted over whole lines 490..491, including their back and front porches. It is not half-line offset.
- All outputs are free-running. There is no stall input.

## Timing
- Counter value at edge t produces pixel-stage outputs at edge t+1.
- in_rgb is sampled at edge t+1+PIPE_DLY.
- out_rgb, hsync, vsync and out_de all update at edge t+2+PIPE_DLY.
- Total latency from counter to pins is PIPE_DLY+2 clocks.
- With PIPE_DLY=0, in_rgb may be combinational from pix_x/pix_y and is sampled the same edge those outputs are visible.
- Reset values (asynchronous, immediate on sys_rst_n low):
  - h_cnt, v_cnt: 0
  - pix_x, pix_y: 0
  - pix_req, frame_start, out_de: 0
  - out_rgb: 0
  - hsync, vsync: 1
  - all delay-line stages: inactive (de=0, syncs=1)
- The first edge after release registers counter state (0,0). pix_req and frame_start therefore go high on the 2nd edge after release.
- Reset mid-frame: all outputs snap to their reset values. The raster restarts at (0,0), with no partial sync pulse carried over.
- Wrap-around: the h_cnt 799→0 and v_cnt 524→0 transitions occur on the same edge. frame_start follows one clock later.
- Period: exactly 800 clocks per line and 420 000 clocks per frame.

## Configuration
- VGA_TEST_PATTERN_EN
  - Defined: the pat_sel port exists.
  - When pat_sel=1, out_rgb ignores in_rgb and shows eight vertical bars of 80 pixels each, selected by pix_x/80.
  - Bar colours, left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Bar colour is computed at the pixel stage and delayed PIPE_DLY clocks. Its alignment is therefore identical to in_rgb's.
  - Blanking still applies.
- Undefined: no pat_sel port and no pattern logic; out_rgb always derives from in_rgb.

## Test plan
- Reset, release, run one frame:
  - frame_start pulses once every 420 000 clocks.
  - pix_req is high for 307 200 clocks per frame.
  - pix_x spans 0..639 and pix_y spans 0..479.
- Sync shape check:
  - hsync low for 96 clocks per line, period 800.
  - The falling edge is exactly 656+PIPE_DLY+1 clocks after the pix_req rise at pix_x=0.
  - vsync low for exactly 1600 clocks per frame.
- Alignment, with PIPE_DLY=1 and a model drawer returning in_rgb = {pix_y[5:0], pix_x[9:0]} one clock later:
  - Every out_de=1 cycle carries out_rgb equal to the expected value for its pixel.
  - out_de is high for 640 consecutive clocks per visible line.
- Blanking: hold in_rgb=16'hFFFF constantly.
  - out_rgb is 0 on every clock where out_de=0.
  - out_rgb is FFFF on every clock where out_de=1.
- Reset asserted mid-line (pix_x=300, pix_y=200):
  - Outputs immediately read 0/0/0 and hsync=vsync=1.
  - After release, frame_start occurs on the 2nd edge.
- With VGA_TEST_PATTERN_EN defined and pat_sel=1:
  - Output pixel x=0 gives FFFF, x=80 gives FFE0, x=639 gives 0000.
  - Bar boundaries fall at multiples of 80 in out_de-aligned time.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing with drawer-latency-matched sync/de/colour output.
// Optional VGA_TEST_PATTERN_EN adds pat_sel and an eight-bar colour pattern.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIPE_DLY  = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  output logic        frame_start,
  input  logic [15:0] in_rgb,
  output logic [15:0] out_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        out_de
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic        pat_sel
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       run;

  // run holds the counters at (0,0) for the first edge after release
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      run   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  logic vis;
  logic fs_c;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    vis    = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    fs_c   = run && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    hs_raw = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs_raw = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_x       <= vis ? h_cnt : 10'd0;
      pix_y       <= vis ? v_cnt : 10'd0;
      pix_req     <= vis;
      frame_start <= fs_c;
    end
  end

  // bit 0 is the pixel stage, bit PIPE_DLY+1 drives the pins
  logic [PIPE_DLY+1:0] de_q;
  logic [PIPE_DLY+1:0] hs_q;
  logic [PIPE_DLY+1:0] vs_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      de_q <= '0;
      hs_q <= '1;
      vs_q <= '1;
    end else begin
      de_q <= {de_q[PIPE_DLY:0], vis};
      hs_q <= {hs_q[PIPE_DLY:0], hs_raw};
      vs_q <= {vs_q[PIPE_DLY:0], vs_raw};
    end
  end

  logic [15:0] rgb_sel;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_VISIBLE / 8;

  logic [2:0]  bar_idx;
  logic [15:0] bar_c;
  logic [15:0] bar_q [PIPE_DLY+1];

  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (h_cnt < 10'((i + 1) * BAR_W)) bar_idx = 3'(i);
    end
    unique case (bar_idx)
      3'd0: bar_c = 16'hFFFF;
      3'd1: bar_c = 16'hFFE0;
      3'd2: bar_c = 16'h07FF;
      3'd3: bar_c = 16'h07E0;
      3'd4: bar_c = 16'hF81F;
      3'd5: bar_c = 16'hF800;
      3'd6: bar_c = 16'h001F;
      3'd7: bar_c = 16'h0000;
    endcase
  end

  // bar colour trails the pixel stage by the drawer latency, like in_rgb
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i <= PIPE_DLY; i++) bar_q[i] <= '0;
    end else begin
      bar_q[0] <= bar_c;
      for (int i = 1; i <= PIPE_DLY; i++) bar_q[i] <= bar_q[i-1];
    end
  end

  assign rgb_sel = pat_sel ? bar_q[PIPE_DLY] : in_rgb;
`else
  assign rgb_sel = in_rgb;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_rgb <= '0;
    end else begin
      out_rgb <= de_q[PIPE_DLY] ? rgb_sel : 16'h0000;
    end
  end

  assign out_de = de_q[PIPE_DLY+1];
  assign hsync  = hs_q[PIPE_DLY+1];
  assign vsync  = vs_q[PIPE_DLY+1];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing, shortened frame height.
// Expected outputs come from the raster position implied by the edge count.
module tb_vga_timing_gen;

  localparam int HV = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VV + VF + VS + VB;
  localparam int D  = 1;
  localparam int FR = HT * VT;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        pix_req;
  logic        frame_start;
  logic [15:0] in_rgb;
  logic [15:0] out_rgb;
  logic        hsync;
  logic        vsync;
  logic        out_de;
`ifdef VGA_TEST_PATTERN_EN
  logic        pat_sel = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int k = 0;
  int mode = 0;
  logic [15:0] cval = 16'h0;
  logic pat = 1'b0;
  logic [15:0] drawer_q;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic agg = 1'b0;
  int fs_k [$];
  int req_cnt = 0;
  int vs_lo = 0;
  int hs_lo = 0;
  int de_run = 0;
  int req_k = -1;
  int hfall_k = -1;
  logic prev_hs = 1'b1;
  int px_max = 0;
  int py_max = 0;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_DLY(D)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_req     (pix_req),
    .frame_start (frame_start),
    .in_rgb      (in_rgb),
    .out_rgb     (out_rgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .out_de      (out_de)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .pat_sel     (pat_sel)
`endif
  );

  always #20 sys_clk = ~sys_clk;

  // model drawer: one clock of latency
  always_ff @(posedge sys_clk) drawer_q <= {pix_y[5:0], pix_x};
  assign in_rgb = (mode == 0) ? drawer_q : cval;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_pix_x"}, 16'(pix_x), 16'd0);
    chk({tag, "_pix_y"}, 16'(pix_y), 16'd0);
    chk({tag, "_pix_req"}, 16'(pix_req), 16'd0);
    chk({tag, "_fs"}, 16'(frame_start), 16'd0);
    chk({tag, "_de"}, 16'(out_de), 16'd0);
    chk({tag, "_rgb"}, out_rgb, 16'd0);
    chk({tag, "_hsync"}, 16'(hsync), 16'd1);
    chk({tag, "_vsync"}, 16'(vsync), 16'd1);
  endtask

  // one clock; edge k shows pixel p=k-2 and output p=k-3-D
  task automatic step();
    int p, h, v;
    logic vis;
    logic [15:0] e;
    @(posedge sys_clk);
    @(negedge sys_clk);
    k++;
    if (k >= 2) begin
      p = (k - 2) % FR;
      h = p % HT;
      v = p / HT;
      vis = (h < HV) && (v < VV);
      chk("pix_x", 16'(pix_x), vis ? 16'(h) : 16'd0);
      chk("pix_y", 16'(pix_y), vis ? 16'(v) : 16'd0);
      chk("pix_req", 16'(pix_req), 16'(vis));
      chk("frame_start", 16'(frame_start), 16'(p == 0));
    end else begin
      chk("pix_x0", 16'(pix_x), 16'd0);
      chk("pix_req0", 16'(pix_req), 16'd0);
      chk("fs0", 16'(frame_start), 16'd0);
    end
    if (k >= 3 + D) begin
      p = (k - 3 - D) % FR;
      h = p % HT;
      v = p / HT;
      vis = (h < HV) && (v < VV);
      if (!vis) e = 16'h0;
      else if (pat) e = bars[h / 80];
      else if (mode == 0) e = {v[5:0], h[9:0]};
      else e = cval;
      chk("out_de", 16'(out_de), 16'(vis));
      chk("out_rgb", out_rgb, e);
      chk("hsync", 16'(hsync), 16'(!(h >= HV + HF && h < HV + HF + HS)));
      chk("vsync", 16'(vsync), 16'(!(v >= VV + VF && v < VV + VF + VS)));
    end else begin
      chk("out_de0", 16'(out_de), 16'd0);
      chk("out_rgb0", out_rgb, 16'd0);
      chk("hsync0", 16'(hsync), 16'd1);
      chk("vsync0", 16'(vsync), 16'd1);
    end
    if (!out_de && de_run != 0) chk("de_run", 16'(de_run), 16'(HV));
    de_run = out_de ? de_run + 1 : 0;
    if (agg) begin
      if (frame_start) fs_k.push_back(k);
      if (pix_req) req_cnt++;
      if (!vsync) vs_lo++;
      if (!hsync) hs_lo++;
      if (pix_req && req_k < 0) req_k = k;
      if (prev_hs && !hsync && hfall_k < 0) hfall_k = k;
      if (int'(pix_x) > px_max) px_max = int'(pix_x);
      if (int'(pix_y) > py_max) py_max = int'(pix_y);
    end
    prev_hs = hsync;
  endtask

  initial begin
    logic found;
    #1 sys_rst_n = 1'b0;
    #5 chk_rst("rst");
    @(negedge sys_clk);
    chk_rst("rst_clk");
    sys_rst_n = 1'b1;
    k = 0;

    agg = 1'b1;
    repeat (2 * FR) step();
    agg = 1'b0;
    chk("fs_count", 16'(fs_k.size()), 16'd2);
    if (fs_k.size() >= 2) begin
      chk("fs_first", 16'(fs_k[0]), 16'd2);
      chk("fs_period", 16'(fs_k[1] - fs_k[0]), 16'(FR));
    end
    chk("req_cnt", 16'(req_cnt), 16'(2 * HV * VV));
    chk("vs_low", 16'(vs_lo), 16'(2 * HT * VS));
    chk("hs_low", 16'(hs_lo), 16'(2 * VT * HS));
    chk("hfall_ofs", 16'(hfall_k - req_k), 16'(HV + HF + D + 1));
    chk("px_max", 16'(px_max), 16'(HV - 1));
    chk("py_max", 16'(py_max), 16'(VV - 1));

    found = 1'b0;
    for (int i = 0; i < 2 * FR && !found; i++) begin
      step();
      found = (pix_x == 10'd300) && (pix_y == 10'd10);
    end
    chk("reach_mid", 16'(found), 16'd1);
    #2 sys_rst_n = 1'b0;
    #1 chk_rst("midrst");
    mode = 1;
    cval = 16'($urandom_range(1, 16'hFFFF));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    k = 0;
    de_run = 0;
    prev_hs = 1'b1;
    step();
    chk("fs_edge1", 16'(frame_start), 16'd0);
    step();
    chk("fs_edge2", 16'(frame_start), 16'd1);
    repeat (FR) step();

`ifdef VGA_TEST_PATTERN_EN
    sys_rst_n = 1'b0;
    #1 chk_rst("patrst");
    pat = 1'b1;
    pat_sel = 1'b1;
    mode = 1;
    cval = 16'($urandom_range(1, 16'hFFFF));
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    k = 0;
    de_run = 0;
    repeat (3 + D) step();
    chk("pat_x0", out_rgb, 16'hFFFF);
    repeat (80) step();
    chk("pat_x80", out_rgb, 16'hFFE0);
    repeat (HV - 81) step();
    chk("pat_x639", out_rgb, 16'h0000);
    repeat (HT * VV) step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
